// File: rtl/csc_pkg.sv
// Shared constants for the three-channel colour-space converter:
// stream flag bit positions, flag widths and the default sample width.
package csc_pkg;
    localparam int W_DEF  = 16;
    localparam int MF_W   = 4;
    localparam int SF_W   = 2;
    localparam int STAGES = 2;

    localparam int FV = 0;
    localparam int FL = 1;
    localparam int FF = 2;
    localparam int FA = 3;
    localparam int FB = 0;
endpackage

// File: rtl/csc_dot3.sv
// One output row of the converter: three signed products registered in stage 1,
// their sum registered (truncated to W bits, wrap-around) in stage 2.
module csc_dot3
    import csc_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [2:0][W-1:0]   a,
    input  logic [2:0][W-1:0]   x,
    output logic [W-1:0]        y
);
    localparam int PW = 2 * W;
    localparam int SW = 2 * W + 2;

    logic signed [PW-1:0] prod [3];
    logic signed [SW-1:0] sum;
    logic                 unused_sum_hi;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < 3; j++) prod[j] <= '0;
        end else if (en) begin
            for (int j = 0; j < 3; j++)
                prod[j] <= PW'($signed(a[j])) * PW'($signed(x[j]));
        end
    end

    always_comb sum = SW'(prod[0]) + SW'(prod[1]) + SW'(prod[2]);

    // Only the low W bits leave the block; overflow wraps by design.
    assign unused_sum_hi = ^sum[SW-1:W];

    always_ff @(posedge clk) begin
        if (rst)     y <= '0;
        else if (en) y <= sum[W-1:0];
    end
endmodule

// File: rtl/csc_matrix.sv
// Streaming 3x3 signed matrix multiply: joins x0/x1/x2 beat by beat, carries the
// x0 flags alongside the two-stage arithmetic pipeline, stalls on consumer busy.
module csc_matrix
    import csc_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W-1:0]    A00,
    input  logic [W-1:0]    A01,
    input  logic [W-1:0]    A02,
    input  logic [W-1:0]    A10,
    input  logic [W-1:0]    A11,
    input  logic [W-1:0]    A12,
    input  logic [W-1:0]    A20,
    input  logic [W-1:0]    A21,
    input  logic [W-1:0]    A22,
    input  logic [W-1:0]    x0_d0,
    input  logic [W-1:0]    x1_d0,
    input  logic [W-1:0]    x2_d0,
    input  logic [MF_W-1:0] x0_mflags,
    input  logic [MF_W-1:0] x1_mflags,
    input  logic [MF_W-1:0] x2_mflags,
    output logic [SF_W-1:0] x0_sflags,
    output logic [SF_W-1:0] x1_sflags,
    output logic [SF_W-1:0] x2_sflags,
    output logic [W-1:0]    y0_d0,
    output logic [W-1:0]    y1_d0,
    output logic [W-1:0]    y2_d0,
    output logic [MF_W-1:0] y0_mflags,
    output logic [MF_W-1:0] y1_mflags,
    output logic [MF_W-1:0] y2_mflags,
    input  logic [SF_W-1:0] y0_sflags,
    input  logic [SF_W-1:0] y1_sflags,
    input  logic [SF_W-1:0] y2_sflags
);
    logic [2:0][2:0][W-1:0] coef;
    logic [2:0][W-1:0]      xv;
    logic [2:0][W-1:0]      yv;
    logic                   stall;
    logic                   accept;
    logic [STAGES:1]        vld_q;
    logic [STAGES:0]        vld_pipe;
    logic [STAGES:1][2:0]   afl_pipe;
    logic [MF_W-1:0]        mflags;
    logic                   unused_flags;

    assign coef[0] = {A02, A01, A00};
    assign coef[1] = {A12, A11, A10};
    assign coef[2] = {A22, A21, A20};
    assign xv      = {x2_d0, x1_d0, x0_d0};

    assign stall  = vld_pipe[STAGES] & (y0_sflags[FB] | y1_sflags[FB] | y2_sflags[FB]);
    // Nothing is consumed during reset, so sources see busy while rst is high.
    assign accept = x0_mflags[FV] & x1_mflags[FV] & x2_mflags[FV] & ~stall & ~rst;
    assign vld_pipe = {vld_q, accept};

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q    <= '0;
            afl_pipe <= '0;
        end else if (!stall) begin
            vld_q       <= vld_pipe[STAGES-1:0];
            afl_pipe[1] <= accept ? {x0_mflags[FA], x0_mflags[FF], x0_mflags[FL]} : 3'b000;
            afl_pipe[2] <= afl_pipe[1];
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_row
        csc_dot3 #(.W(W)) u_row (
            .clk (clk),
            .rst (rst),
            .en  (~stall),
            .a   (coef[i]),
            .x   (xv),
            .y   (yv[i])
        );
    end

    assign mflags    = {afl_pipe[STAGES], vld_pipe[STAGES]};
    assign y0_mflags = mflags;
    assign y1_mflags = mflags;
    assign y2_mflags = mflags;
    assign y0_d0     = yv[0];
    assign y1_d0     = yv[1];
    assign y2_d0     = yv[2];

    assign x0_sflags = {1'b0, ~accept};
    assign x1_sflags = {1'b0, ~accept};
    assign x2_sflags = {1'b0, ~accept};

    assign unused_flags = ^{x1_mflags[MF_W-1:1], x2_mflags[MF_W-1:1],
                            y0_sflags[1], y1_sflags[1], y2_sflags[1]};
endmodule

// File: tb/tb_csc_matrix.sv
// Randomized and directed checks of csc_matrix against a beat-level scoreboard
// that computes A*x with plain integer arithmetic at each observed accept.
module tb_csc_matrix;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] a  [3][3];
    logic [W-1:0] xd [3];
    logic [3:0]   xf [3];
    logic [1:0]   xs [3];
    logic [W-1:0] yd [3];
    logic [3:0]   yf [3];
    logic [1:0]   ys [3];

    always #5 clk = ~clk;

    csc_matrix #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .A00(a[0][0]), .A01(a[0][1]), .A02(a[0][2]),
        .A10(a[1][0]), .A11(a[1][1]), .A12(a[1][2]),
        .A20(a[2][0]), .A21(a[2][1]), .A22(a[2][2]),
        .x0_d0(xd[0]), .x1_d0(xd[1]), .x2_d0(xd[2]),
        .x0_mflags(xf[0]), .x1_mflags(xf[1]), .x2_mflags(xf[2]),
        .x0_sflags(xs[0]), .x1_sflags(xs[1]), .x2_sflags(xs[2]),
        .y0_d0(yd[0]), .y1_d0(yd[1]), .y2_d0(yd[2]),
        .y0_mflags(yf[0]), .y1_mflags(yf[1]), .y2_mflags(yf[2]),
        .y0_sflags(ys[0]), .y1_sflags(ys[1]), .y2_sflags(ys[2])
    );

    typedef struct packed {
        logic [2:0][W-1:0] y;
        logic [3:0]        f;
        int                acc_cyc;
    } beat_t;

    beat_t             sb[$];
    int                checks = 0;
    int                errors = 0;
    int                cycle  = 0;
    logic              chk_lat = 1'b0;
    logic              held = 1'b0;
    logic              last_acc = 1'b0;
    logic [2:0][W-1:0] hy;
    logic [3:0]        hf;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", tag, act, exp, cycle);
        end
    endtask

    function automatic logic [W-1:0] dot(input int i);
        longint s = 0;
        for (int j = 0; j < 3; j++)
            s += longint'($signed(a[i][j])) * longint'($signed(xd[j]));
        return s[W-1:0];
    endfunction

    // One clock: observe at negedge, update the scoreboard, step past posedge.
    task automatic cyc();
        logic  allv, anyb, stall_obs;
        beat_t b;
        @(negedge clk);
        allv      = xf[0][0] & xf[1][0] & xf[2][0];
        anyb      = ys[0][0] | ys[1][0] | ys[2][0];
        stall_obs = (yf[0][0] === 1'b1) && anyb;
        for (int i = 0; i < 3; i++) begin
            chk("x_rsv", 64'(xs[i][1]), 64'd0);
            chk("x_busy", 64'(xs[i][0]), (rst || !allv) ? 64'd1 : 64'(stall_obs));
        end
        if (held && !rst) begin
            for (int i = 0; i < 3; i++) begin
                chk("hold_d", 64'(yd[i]), 64'(hy[i]));
                chk("hold_f", 64'(yf[i]), 64'(hf));
            end
        end
        held = 1'b0;
        if (!rst && yf[0][0] === 1'b1) begin
            if (anyb) begin
                held = 1'b1;
                hf   = yf[0];
                for (int i = 0; i < 3; i++) hy[i] = yd[i];
            end else if (sb.size() == 0) begin
                chk("spurious_beat", 64'd1, 64'd0);
            end else begin
                b = sb.pop_front();
                for (int i = 0; i < 3; i++) begin
                    chk("y_data", 64'(yd[i]), 64'(b.y[i]));
                    chk("y_flags", 64'(yf[i]), 64'(b.f));
                end
                if (chk_lat) chk("latency", 64'(cycle - b.acc_cyc), 64'd2);
            end
        end
        last_acc = !rst && allv && (xs[0][0] === 1'b0);
        if (last_acc) begin
            for (int i = 0; i < 3; i++) b.y[i] = dot(i);
            b.f       = {xf[0][3:1], 1'b1};
            b.acc_cyc = cycle;
            sb.push_back(b);
        end
        @(posedge clk);
        cycle++;
        if (rst) begin
            sb.delete();
            held = 1'b0;
        end
        #1;
    endtask

    task automatic feed(input logic [W-1:0] v0, input logic [W-1:0] v1,
                        input logic [W-1:0] v2, input logic [3:0] f);
        xd[0] = v0; xd[1] = v1; xd[2] = v2;
        xf[0] = f | 4'b0001; xf[1] = 4'b0001; xf[2] = 4'b0001;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (last_acc) return;
        end
        chk("feed_timeout", 64'd1, 64'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < 3; i++) xf[i] = 4'b0000;
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic set_coef(input int m00, input int m01, input int m02,
                            input int m10, input int m11, input int m12,
                            input int m20, input int m21, input int m22);
        a[0][0] = W'(m00); a[0][1] = W'(m01); a[0][2] = W'(m02);
        a[1][0] = W'(m10); a[1][1] = W'(m11); a[1][2] = W'(m12);
        a[2][0] = W'(m20); a[2][1] = W'(m21); a[2][2] = W'(m22);
    endtask

    // A source with V=1 that was not accepted keeps its beat unchanged.
    task automatic src_update(input int vprob);
        for (int i = 0; i < 3; i++) begin
            if (last_acc || !xf[i][0]) begin
                if (int'($urandom_range(0, 99)) < vprob) begin
                    xd[i] = W'($urandom);
                    xf[i] = {3'($urandom_range(0, 7)), 1'b1};
                end else begin
                    xf[i] = 4'b0000;
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            xd[i] = '0; xf[i] = '0; ys[i] = '0;
        end
        set_coef(1, 0, 0, 0, 1, 0, 0, 0, 1);

        rst = 1'b1;
        cyc(); cyc();
        for (int i = 0; i < 3; i++) begin
            chk("rst_d0", 64'(yd[i]), 64'd0);
            chk("rst_mflags", 64'(yf[i]), 64'd0);
        end
        rst = 1'b0;

        chk_lat = 1'b1;
        feed(1, 2, 3, 4'b0001);
        feed(4, 5, 6, 4'b0001);
        idle(4);

        set_coef(1, 1, 1, -1, 4, -1, 0, 0, 3);
        feed(1, 2, 3, 4'b0101);
        feed(5, 6, 7, 4'b1011);
        idle(4);

        xd[0] = 16'd9; xd[1] = 16'd0; xd[2] = 16'hFFF0;
        xf[0] = 4'b0011; xf[1] = 4'b0000; xf[2] = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("join_noacc", 64'(last_acc), 64'd0);
        end
        feed(16'd9, 16'd100, 16'hFFF0, 4'b0011);
        idle(4);

        set_coef(4, 0, 0, 0, 0, 0, 0, 0, 0);
        feed(16'h4000, 16'h1234, 16'h7FFF, 4'b0001);
        idle(4);

        set_coef(2, -3, 1, 7, 0, -1, 1, 1, 1);
        feed(10, 20, 30, 4'b0001);
        feed(-5, 8, 2, 4'b0001);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) xf[i] = 4'b0000;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("midrst_d0", 64'(yd[i]), 64'd0);
            chk("midrst_mflags", 64'(yf[i]), 64'd0);
        end
        idle(5);

        chk_lat = 1'b0;
        for (int k = 0; k < 1200; k++) begin
            if (k % 97 == 0)
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++) a[i][j] = W'($urandom);
            ys[1][0] = (cycle % 12) < 2;
            ys[0]    = (k >= 600) ? 2'($urandom_range(0, 3) == 0 ? 2'b01 : 2'b10) : 2'b00;
            ys[2][1] = 1'($urandom);
            src_update(k < 600 ? 100 : 70);
            cyc();
        end
        for (int i = 0; i < 3; i++) ys[i] = 2'b00;
        idle(6);
        chk("drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
